// File: rtl/dram_word_arbiter.sv
// Two-requester word arbiter/sequencer in front of a byte-wide scratch DRAM.
// Define DRAM_WORD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module dram_word_arbiter #(
  parameter int NUM_DATA = 512,
  parameter int ADDR_W   = 29
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [15:0]       req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [15:0]       req1_wdata,
  output logic              req1_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic              rsp_we,
  output logic [15:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_q,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, TAIL = 2'd3} state_e;

  // Highest legal low-byte address: the high byte at A+1 must still be in the RAM.
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(NUM_DATA - 2);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_hi_q, wdata_hi_d;
  logic [7:0]        rdata_lo_q, rdata_lo_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic              rsp_we_q, rsp_we_d;
  logic              rsp_err_q, rsp_err_d;
  logic [15:0]       rsp_rdata_q, rsp_rdata_d;

  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [ADDR_W-1:0] mem_raddr_q, mem_raddr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic              gnt_any;
  logic              gnt_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_wdata;
  logic              sel_err;

`ifndef DRAM_WORD_ARB_FIXED_PRIO_EN
  logic last_grant_q;

  // Resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (gnt_any) begin
      last_grant_q <= gnt_id;
    end
  end
`endif

  // Grants only in IDLE and never while reset is asserted.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      gnt_any = req0_valid | req1_valid;
`ifdef DRAM_WORD_ARB_FIXED_PRIO_EN
      gnt_id  = ~req0_valid;
`else
      if (req0_valid && req1_valid) begin
        gnt_id = ~last_grant_q;
      end else begin
        gnt_id = ~req0_valid;
      end
`endif
    end
  end

  assign req0_ready = gnt_any & ~gnt_id;
  assign req1_ready = gnt_any & gnt_id;

  assign sel_we    = gnt_id ? req1_we    : req0_we;
  assign sel_addr  = gnt_id ? req1_addr  : req0_addr;
  assign sel_wdata = gnt_id ? req1_wdata : req0_wdata;
  assign sel_err   = (sel_addr > MAX_ADDR);

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_hi_d  = wdata_hi_q;
    rdata_lo_d  = rdata_lo_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_we_d    = rsp_we_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_raddr_d = mem_raddr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          if (sel_err) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_id;
            rsp_we_d    = sel_we;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 16'h0000;
          end else begin
            state_d    = LO;
            id_d       = gnt_id;
            we_d       = sel_we;
            addr_d     = sel_addr;
            wdata_hi_d = sel_wdata[15:8];
            // Low-byte access is launched on the grant edge so it is live in LO.
            if (sel_we) begin
              mem_we_d    = 1'b1;
              mem_waddr_d = sel_addr;
              mem_wdata_d = sel_wdata[7:0];
            end else begin
              mem_raddr_d = sel_addr;
            end
          end
        end
      end
      LO: begin
        state_d = HI;
        if (we_q) begin
          mem_we_d    = 1'b1;
          mem_waddr_d = addr_q + ADDR_ONE;
          mem_wdata_d = wdata_hi_q;
        end else begin
          mem_raddr_d = addr_q + ADDR_ONE;
        end
      end
      HI: begin
        if (we_q) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_we_d    = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 16'h0000;
        end else begin
          state_d    = TAIL;
          rdata_lo_d = mem_q;
        end
      end
      TAIL: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_we_d    = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = {mem_q, rdata_lo_q};
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      id_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_hi_q  <= 8'h00;
      rdata_lo_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_raddr_q <= '0;
      mem_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_hi_q  <= wdata_hi_d;
      rdata_lo_q  <= rdata_lo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_raddr_q <= mem_raddr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_we      = rsp_we_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign busy        = (state_q != IDLE);
  assign mem_we      = mem_we_q;
  assign mem_waddr   = mem_waddr_q;
  assign mem_raddr   = mem_raddr_q;
  assign mem_wdata   = mem_wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dram_word_arbiter.sv
// Directed bench for dram_word_arbiter with a byte-wide DRAM model attached.
// Handshake: a request is accepted on the rising edge where reqN_valid && reqN_ready.
module tb_dram_word_arbiter;
  localparam int NUM_DATA = 512;
  localparam int ADDR_W   = 29;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req0_we, req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [15:0]       req0_wdata;
  logic              req1_valid, req1_we, req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [15:0]       req1_wdata;
  logic              rsp_valid, rsp_id, rsp_we, rsp_err, busy;
  logic [15:0]       rsp_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [7:0]        mem_wdata, mem_q;
  logic [1:0]        dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  dram_word_arbiter #(.NUM_DATA(NUM_DATA), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
    .mem_wdata(mem_wdata), .mem_q(mem_q), .dbg_state_o(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Byte DRAM: synchronous write, registered read
  logic [7:0] dram [0:NUM_DATA-1];
  always @(posedge clk) begin
    if (mem_we) dram[mem_waddr[8:0]] <= mem_wdata;
    mem_q <= dram[mem_raddr[8:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [15:0] d);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [15:0] d);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got, prev, exp_id;
    int c0, c1, n;

    rst_n = 1'b0;
    drive0(1'b0, 1'b0, '0, 16'h0);
    drive1(1'b0, 1'b0, '0, 16'h0);
    repeat (3) tick();

    // Reset state, with a request already pending
    drive0(1'b1, 1'b1, 29'h10, 16'hBEEF);
    #1;
    check("rst_ready0", req0_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_waddr", mem_waddr, 0);
    check("rst_mem_raddr", mem_raddr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_state", dbg_state, 0);

    // Word write from requester 0
    rst_n = 1'b1;
    #1;
    check("wr_ready0", req0_ready, 1);
    check("wr_ready1", req1_ready, 0);
    tick();
    drive0(1'b0, 1'b0, '0, 16'h0);
    check("wr_lo_we", mem_we, 1);
    check("wr_lo_addr", mem_waddr, 32'h10);
    check("wr_lo_data", mem_wdata, 32'hEF);
    check("wr_lo_busy", busy, 1);
    tick();
    check("wr_hi_we", mem_we, 1);
    check("wr_hi_addr", mem_waddr, 32'h11);
    check("wr_hi_data", mem_wdata, 32'hBE);
    check("wr_hi_rsp", rsp_valid, 0);
    tick();
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_id", rsp_id, 0);
    check("wr_rsp_we", rsp_we, 1);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_rsp_memwe", mem_we, 0);
    check("wr_rsp_busy", busy, 0);

    // Word read from requester 1 of the same address
    drive1(1'b1, 1'b0, 29'h10, 16'h0);
    exp_q.push_back(16'hBEEF);
    #1;
    check("rd_ready1", req1_ready, 1);
    tick();
    drive1(1'b0, 1'b0, '0, 16'h0);
    check("rd_lo_raddr", mem_raddr, 32'h10);
    check("rd_lo_we", mem_we, 0);
    tick();
    check("rd_hi_raddr", mem_raddr, 32'h11);
    check("rd_hi_we", mem_we, 0);
    tick();
    check("rd_tail_busy", busy, 1);
    check("rd_tail_rsp", rsp_valid, 0);
    check("rd_tail_we", mem_we, 0);
    tick();
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_id", rsp_id, 1);
    check("rd_rsp_we", rsp_we, 0);
    check("rd_rsp_err", rsp_err, 0);
    check("rd_rsp_rdata", rsp_rdata, exp_q.pop_front());

    // Both requesters writing continuously, 4 writes each
    c0 = 0; c1 = 0; prev = 1'b0;
    drive0(1'b1, 1'b1, 29'h20, 16'h1111);
    drive1(1'b1, 1'b1, 29'h40, 16'h2222);
    #1;
    for (int g = 0; g < 8; g++) begin
      n = 0;
      while (!req0_ready && !req1_ready && n < 10) begin
        tick();
        n++;
      end
      check("arb_wait_bound", (n < 10), 1);
      got = req1_ready;
`ifdef DRAM_WORD_ARB_FIXED_PRIO_EN
      exp_id = (g >= 4);
`else
      exp_id = g[0];
`endif
      check("arb_grant", got, exp_id);
      if (g > 0) begin
        check("wr_spacing", n, 2);
        check("arb_rsp_valid", rsp_valid, 1);
        check("arb_rsp_id", rsp_id, prev);
      end
      prev = got;
      if (got) c1++; else c0++;
      tick();
      if (c0 == 4) req0_valid = 1'b0;
      if (c1 == 4) req1_valid = 1'b0;
    end
    tick();
    tick();
    check("arb_last_rsp", rsp_valid, 1);
    check("arb_last_id", rsp_id, prev);
    check("arb_last_we", rsp_we, 1);

    // Out-of-bounds read at NUM_DATA-1
    drive0(1'b1, 1'b0, 29'd511, 16'h0);
    #1;
    check("err_ready0", req0_ready, 1);
    tick();
    drive0(1'b0, 1'b0, '0, 16'h0);
    check("err_rsp_valid", rsp_valid, 1);
    check("err_rsp_err", rsp_err, 1);
    check("err_rsp_rdata", rsp_rdata, 0);
    check("err_rsp_id", rsp_id, 0);
    check("err_mem_we", mem_we, 0);
    check("err_busy", busy, 0);

    // Highest legal address NUM_DATA-2 is accepted
    drive0(1'b1, 1'b1, 29'd510, 16'h1234);
    #1;
    check("top_ready0", req0_ready, 1);
    tick();
    drive0(1'b0, 1'b0, '0, 16'h0);
    check("top_lo_we", mem_we, 1);
    check("top_lo_addr", mem_waddr, 32'd510);
    check("top_lo_data", mem_wdata, 32'h34);
    tick();
    check("top_hi_addr", mem_waddr, 32'd511);
    check("top_hi_data", mem_wdata, 32'h12);
    tick();
    check("top_rsp_valid", rsp_valid, 1);
    check("top_rsp_err", rsp_err, 0);

    // Back-to-back reads: 510 then 0x20 (written by requester 0 above)
    drive0(1'b1, 1'b0, 29'd510, 16'h0);
    exp_q.push_back(16'h1234);
    #1;
    check("rr_ready0", req0_ready, 1);
    tick();
    req0_addr = 29'h20;
    exp_q.push_back(16'h1111);
    n = 0;
    while (!req0_ready && n < 10) begin
      tick();
      n++;
    end
    check("rd_spacing", n, 3);
    check("rr1_rsp_valid", rsp_valid, 1);
    check("rr1_rsp_err", rsp_err, 0);
    check("rr1_rsp_rdata", rsp_rdata, exp_q.pop_front());
    tick();
    drive0(1'b0, 1'b0, '0, 16'h0);
    repeat (3) tick();
    check("rr2_rsp_valid", rsp_valid, 1);
    check("rr2_rsp_rdata", rsp_rdata, exp_q.pop_front());

    // Reset during HI of a write
    drive0(1'b1, 1'b1, 29'h30, 16'hA5C3);
    #1;
    check("mid_ready0", req0_ready, 1);
    tick();
    drive0(1'b0, 1'b0, '0, 16'h0);
    tick();
    check("mid_hi_we", mem_we, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_waddr", mem_waddr, 0);
    check("mid_rst_wdata", mem_wdata, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp", rsp_valid, 0);
    check("mid_rst_state", dbg_state, 0);
    tick();
    tick();
    check("mid_no_rsp", rsp_valid, 0);
    drive0(1'b1, 1'b1, 29'h30, 16'h5A3C);
    drive1(1'b1, 1'b1, 29'h50, 16'h7777);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready0", req0_ready, 1);
    check("post_rst_ready1", req1_ready, 0);
    tick();
    drive0(1'b0, 1'b0, '0, 16'h0);
    drive1(1'b0, 1'b0, '0, 16'h0);
    tick();
    tick();
    check("post_rst_rsp", rsp_valid, 1);
    check("post_rst_id", rsp_id, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_word_arbiter.md
Name: dram_word_arbiter

Overview:
Two-requester round-robin arbiter and sequencer in front of the 8-bit byte-addressed `dram` block (synchronous write, 1-cycle registered read).
- Each requester issues 16-bit word reads/writes.
- The block serialises each word into two byte accesses, little-endian (low byte at A, high byte at A+1).
- Returns a tagged response on a shared response channel.
- Sits between compute engines (e.g. conv-layer load/store units) and the shared scratch DRAM.

Parameters:
- NUM_DATA, 512, depth in bytes of the attached dram; used for bounds check.
- ADDR_W, 29, byte address width; matches dram waddr_byte/raddr_byte.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a request
- req0_we  in  1  1 = word write, 0 = word read
- req0_addr  in  ADDR_W  byte address of low byte
- req0_wdata  in  16  write data
- req0_ready  out  1  request 0 accepted this cycle
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready  same as requester 0, for requester 1
- rsp_valid  out  1  one-cycle response pulse (read data or write done)
- rsp_id  out  1  requester that owns the response
- rsp_we  out  1  response is for a write
- rsp_rdata  out  16  read word; 0 for writes/errors
- rsp_err  out  1  request was out of bounds
- busy  out  1  FSM not in IDLE
- mem_we  out  1  to dram we
- mem_waddr  out  ADDR_W  to dram waddr_byte
- mem_raddr  out  ADDR_W  to dram raddr_byte
- mem_wdata  out  8  to dram data
- mem_q  in  8  from dram q; valid 1 cycle after mem_raddr

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0: ready, rsp_*, busy, mem_we, addresses, wdata.
  - last_grant=1, so requester 0 wins the first tie.
- States: IDLE, LO, HI, TAIL.
- IDLE:
  - If any reqN_valid, grant one requester and pulse reqN_ready=1 (combinational, same cycle T).
  - Latch id, we, addr, wdata; go to LO.
  - Requester must hold valid/addr/wdata stable until ready.
  - ready is only ever high in IDLE.
- Arbitration:
  - Single valid wins.
  - Both valid: grant the requester not equal to last_grant; update last_grant on every grant.
- Bounds check at grant: error if addr > NUM_DATA-2, i.e. the high byte falls outside the RAM.
  - No memory access is made; mem_we stays 0.
  - Next state goes directly to a response: rsp_valid=1, rsp_err=1, rsp_rdata=0 at T+1; IDLE at T+1.
- Write (in range):
  - T+1 LO: mem_we=1, mem_waddr=A, mem_wdata=wdata[7:0].
  - T+2 HI: mem_we=1, mem_waddr=A+1, mem_wdata=wdata[15:8].
  - T+3: rsp_valid=1, rsp_we=1, rsp_id; state IDLE, so a new grant is possible at T+3.
- Read (in range):
  - T+1 LO: mem_raddr=A.
  - T+2 HI: mem_raddr=A+1; capture mem_q into rdata[7:0].
  - T+3 TAIL: capture mem_q into rdata[15:8].
  - T+4: rsp_valid=1, rsp_rdata valid; state IDLE.
- mem_we=0 in every non-write cycle.
- mem_waddr/mem_raddr hold their last value when unused.
- A+1 computed modulo 2^ADDR_W; unreachable in range because of the bounds check.
- rsp_* registered; rsp_valid high exactly one cycle per accepted request; rsp_id/rsp_we/rsp_err/rsp_rdata meaningful only when rsp_valid=1.
- No outstanding requests beyond one; busy=1 in LO/HI/TAIL.
- Reset asserted mid-operation: transaction abandoned, no response, outputs zero immediately; dram contents not restored (a partial write may leave only the low byte written).

Optional Feature:
- Macro: DRAM_WORD_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins when both are valid; last_grant unused.
- Undefined: round-robin as above.

Test Plan:
- Reset release, req0 write A=0x10, wdata=0xBEEF: ready0 at T; mem_we at T+1 (addr 0x10, data 0xEF) and T+2 (addr 0x11, data 0xBE); rsp_valid at T+3 with id=0, we=1, err=0.
- Then req1 read A=0x10: rsp_valid at T+4 with id=1, rsp_rdata=0xBEEF; mem_we=0 throughout.
- Both valid continuously, 4 writes each: grants alternate 0,1,0,1,…, first grant to 0. With DRAM_WORD_ARB_FIXED_PRIO_EN, all grants go to 0 while req0_valid is held.
- req0 read A=NUM_DATA-1 (511): rsp_err=1, rsp_rdata=0 at T+1, no mem_we. A=510 is in range and succeeds.
- Back-to-back writes from req0: second ready exactly 3 cycles after the first; reads spaced 4 cycles apart.
- Assert rst_n=0 during HI of a write: all outputs 0 asynchronously, no rsp_valid; after release req0 is granted first.
